sirali_bolucu: RTL
==================

Name: sirali_bolucu

Overview:
- Multi-cycle radix-2 integer divider; the responder side of the execute-stage M-extension unit's divide request (basla/hazir) interface.
- Accepts a single start pulse with operands and returns quotient and remainder per RISC-V DIV/DIVU/REM/REMU semantics.
- Holds its result valid until the next request or a cancel.
- Replaces the reset-based restart with an explicit cancel input.

Parameters:
VERI_BIT, 32, operand/result width in bits (must be >= 2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
basla_i  input  1  start pulse; operands sampled on the same edge
iptal_i  input  1  cancel current operation, return to idle
bolunen_i  input  VERI_BIT  dividend (rs1)
bolen_i  input  VERI_BIT  divisor (rs2)
isaretli_bolme_i  input  1  1 = signed (DIV/REM), 0 = unsigned
bolum_o  output  VERI_BIT  quotient
kalan_o  output  VERI_BIT  remainder
hazir_o  output  1  result valid
mesgul_o  output  1  operation in progress

Behaviour:
- One clock, clk_i; reset rst_i is asynchronous, active-high.
- Reset, asynchronous: state=BOSTA; bolum_o=0, kalan_o=0, hazir_o=0, mesgul_o=0; all internal registers cleared.
- States: BOSTA, HESAPLA, DUZELT, BITTI.
- Start acceptance:
  - basla_i is accepted in BOSTA or BITTI only. basla_i in HESAPLA or DUZELT is ignored.
  - On the acceptance edge the block registers operand magnitudes, the signed flag, the quotient sign (sign(a) XOR sign(b), signed only) and the remainder sign (sign(a), signed only). It clears hazir_o.
- Special cases, decided on the acceptance edge; go directly to BITTI, so hazir_o=1 one cycle after acceptance:
  - bolen_i==0: bolum_o = all ones; kalan_o = bolunen_i (both modes).
  - Signed, bolunen_i = most-negative and bolen_i = -1: bolum_o = bolunen_i; kalan_o = 0.
- Normal path:
  - Enter HESAPLA with the iteration counter = VERI_BIT-1.
  - Each cycle, one restoring step: shift the partial remainder left and bring in the next dividend MSB. Subtract the divisor magnitude; if non-negative, keep the difference and set the quotient bit to 1, else set the bit to 0.
  - Counter decrements each cycle; when counter==0 the step executes and the state goes to DUZELT.
  - DUZELT: apply the negations (quotient if its sign flag is set, remainder if its sign flag is set), register bolum_o/kalan_o, go to BITTI.
  - Latency, acceptance edge to hazir_o=1: VERI_BIT+2 cycles (34 for 32-bit).
- Partial-remainder register is VERI_BIT+1 bits wide so the subtract never overflows. Most-negative operand magnitude must be handled as an unsigned VERI_BIT value.
- BITTI:
  - hazir_o=1; bolum_o/kalan_o stable.
  - Held indefinitely until a new basla_i is accepted (hazir_o drops on that edge) or iptal_i.
- mesgul_o=1 exactly in HESAPLA and DUZELT.
- iptal_i:
  - Synchronous, highest priority after reset. Any state goes to BOSTA; hazir_o=0.
  - bolum_o/kalan_o keep their last values (don't-care).
  - iptal_i and basla_i on the same edge: iptal_i wins; the start is dropped.
- Operand changes on bolunen_i/bolen_i/isaretli_bolme_i after acceptance have no effect.
- Unsigned mode: operands are treated as magnitudes and no negation is applied.
- Reset mid-operation: immediate return to BOSTA with all outputs 0. The first basla_i after reset deasserts is accepted normally.

Test Plan:
- Unsigned 100 / 7, basla_i one cycle -> mesgul_o=1 for 33 cycles; hazir_o=1 at cycle 34 after acceptance; bolum_o=14, kalan_o=2; hazir_o held while basla_i is low.
- Signed -7 / 2 -> bolum_o=0xFFFFFFFD, kalan_o=0xFFFFFFFF. Signed 7 / -2 -> bolum_o=0xFFFFFFFD, kalan_o=1. Unsigned 0xFFFFFFFF / 2 -> 0x7FFFFFFF, remainder 1.
- Divide by zero: 0x12345678 / 0 (signed and unsigned) -> hazir_o one cycle after acceptance; bolum_o=0xFFFFFFFF, kalan_o=0x12345678. Signed 0x80000000 / 0xFFFFFFFF -> bolum_o=0x80000000, kalan_o=0, 1-cycle latency.
- basla_i pulsed again at cycle 10 of an operation -> ignored; original result 1000/10 = 100 r 0 delivered at cycle 34. Then new basla_i while in BITTI -> hazir_o drops the same edge and the new result follows.
- iptal_i at cycle 15 -> BOSTA next edge, hazir_o and mesgul_o stay 0. iptal_i together with basla_i -> no operation started.
- rst_i asserted asynchronously mid-HESAPLA (between edges) -> outputs 0 immediately. After release, 0x80000000 / 3 signed -> bolum_o=0xD5555556, kalan_o=0xFFFFFFFE.

Source files
------------

// File: rtl/sirali_bolucu.sv
// Multi-cycle radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow finish on the start edge.
module sirali_bolucu #(
  parameter int VERI_BIT = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                basla_i,
  input  logic                iptal_i,
  input  logic [VERI_BIT-1:0] bolunen_i,
  input  logic [VERI_BIT-1:0] bolen_i,
  input  logic                isaretli_bolme_i,
  output logic [VERI_BIT-1:0] bolum_o,
  output logic [VERI_BIT-1:0] kalan_o,
  output logic                hazir_o,
  output logic                mesgul_o
);

  localparam int SAYAC_W = $clog2(VERI_BIT);

  typedef enum logic [1:0] {BOSTA, HESAPLA, DUZELT, BITTI} durum_t;

  durum_t durum_q, durum_d;

  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic [VERI_BIT:0]   kalan_kismi_q, kalan_kismi_d;
  logic [VERI_BIT-1:0] bolum_kaydirma_q, bolum_kaydirma_d;
  logic [VERI_BIT-1:0] bolen_q, bolen_d;
  logic                bolum_isaret_q, bolum_isaret_d;
  logic                kalan_isaret_q, kalan_isaret_d;
  logic [VERI_BIT-1:0] bolum_q, bolum_d;
  logic [VERI_BIT-1:0] kalan_q, kalan_d;

  logic                kabul;
  logic                sifira_bolme;
  logic                tasma;
  logic                a_negatif, b_negatif;
  logic [VERI_BIT-1:0] a_buyukluk, b_buyukluk;
  logic [VERI_BIT+1:0] kaydir, fark;

  always_comb begin
    kabul        = basla_i && !iptal_i && (durum_q == BOSTA || durum_q == BITTI);
    sifira_bolme = (bolen_i == '0);
    tasma        = isaretli_bolme_i && (bolunen_i == {1'b1, {(VERI_BIT-1){1'b0}}})
                   && (bolen_i == '1);
    a_negatif    = isaretli_bolme_i && bolunen_i[VERI_BIT-1];
    b_negatif    = isaretli_bolme_i && bolen_i[VERI_BIT-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    a_buyukluk   = a_negatif ? (~bolunen_i + 1'b1) : bolunen_i;
    b_buyukluk   = b_negatif ? (~bolen_i + 1'b1) : bolen_i;
    kaydir       = {kalan_kismi_q, bolum_kaydirma_q[VERI_BIT-1]};
    fark         = kaydir - {2'b00, bolen_q};
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  // Next-state logic
  always_comb begin
    durum_d = durum_q;
    if (iptal_i) begin
      durum_d = BOSTA;
    end else begin
      unique case (durum_q)
        BOSTA, BITTI: if (kabul) durum_d = (sifira_bolme || tasma) ? BITTI : HESAPLA;
        HESAPLA:      if (sayac_q == '0) durum_d = DUZELT;
        DUZELT:       durum_d = BITTI;
        default:      durum_d = BOSTA;
      endcase
    end
  end

  // Output logic
  always_comb begin
    hazir_o  = (durum_q == BITTI);
    mesgul_o = (durum_q == HESAPLA) || (durum_q == DUZELT);
    bolum_o  = bolum_q;
    kalan_o  = kalan_q;
  end

  // Datapath next-state
  always_comb begin
    // NOTE: every _d starts at its _q so no path through this block can infer a latch.
    sayac_d          = sayac_q;
    kalan_kismi_d    = kalan_kismi_q;
    bolum_kaydirma_d = bolum_kaydirma_q;
    bolen_d          = bolen_q;
    bolum_isaret_d   = bolum_isaret_q;
    kalan_isaret_d   = kalan_isaret_q;
    bolum_d          = bolum_q;
    kalan_d          = kalan_q;

    if (kabul) begin
      sayac_d          = SAYAC_W'(VERI_BIT - 1);
      kalan_kismi_d    = '0;
      bolum_kaydirma_d = a_buyukluk;
      bolen_d          = b_buyukluk;
      bolum_isaret_d   = a_negatif ^ b_negatif;
      kalan_isaret_d   = a_negatif;
      if (sifira_bolme) begin
        bolum_d = '1;
        kalan_d = bolunen_i;
      end else if (tasma) begin
        bolum_d = bolunen_i;
        kalan_d = '0;
      end
    end else if (!iptal_i && durum_q == HESAPLA) begin
      sayac_d = sayac_q - 1'b1;
      if (!fark[VERI_BIT+1]) begin
        kalan_kismi_d    = fark[VERI_BIT:0];
        bolum_kaydirma_d = {bolum_kaydirma_q[VERI_BIT-2:0], 1'b1};
      end else begin
        kalan_kismi_d    = kaydir[VERI_BIT:0];
        bolum_kaydirma_d = {bolum_kaydirma_q[VERI_BIT-2:0], 1'b0};
      end
    end else if (!iptal_i && durum_q == DUZELT) begin
      bolum_d = bolum_isaret_q ? (~bolum_kaydirma_q + 1'b1) : bolum_kaydirma_q;
      kalan_d = kalan_isaret_q ? (~kalan_kismi_q[VERI_BIT-1:0] + 1'b1)
                               : kalan_kismi_q[VERI_BIT-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_q          <= '0;
      kalan_kismi_q    <= '0;
      bolum_kaydirma_q <= '0;
      bolen_q          <= '0;
      bolum_isaret_q   <= 1'b0;
      kalan_isaret_q   <= 1'b0;
      bolum_q          <= '0;
      kalan_q          <= '0;
    end else begin
      sayac_q          <= sayac_d;
      kalan_kismi_q    <= kalan_kismi_d;
      bolum_kaydirma_q <= bolum_kaydirma_d;
      bolen_q          <= bolen_d;
      bolum_isaret_q   <= bolum_isaret_d;
      kalan_isaret_q   <= kalan_isaret_d;
      bolum_q          <= bolum_d;
      kalan_q          <= kalan_d;
    end
  end

endmodule
